// File: rtl/residue_mod5_tx_if.sv
// Handshake and serial-link bundle for residue_mod5_tx.
// The slave modport is the transmitter side; the master modport is the word producer and link observer.
interface residue_mod5_tx_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             frame_start;
  logic             chk_phase;
  logic [2:0]       res;
  logic             frame_done;

  modport master (
    output in_valid, in_data,
    input  in_ready, ser_out, ser_valid, frame_start, chk_phase, res, frame_done
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, ser_out, ser_valid, frame_start, chk_phase, res, frame_done
  );
endinterface

// File: rtl/residue_mod5_tx.sv
// MSB-first serial transmitter that tracks the running residue mod 5 of the bits it sends.
// Define RESIDUE_TX_CHECK_EN to append the 3-bit final residue after the data bits.
//
// state | meaning
// IDLE  | waiting for a word, in_ready high
// DATA  | shifting data bits out, residue updating
// CHK   | sending the frozen final residue, MSB first (RESIDUE_TX_CHECK_EN only)
module residue_mod5_tx #(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  residue_mod5_tx_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CHK  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sh;
  logic [CW-1:0]    cnt;
  logic             ser_q;
  logic             ser_valid_q;
  logic             frame_start_q;
  logic             chk_phase_q;
  logic [2:0]       res_q;
  logic             frame_done_q;
`ifdef RESIDUE_TX_CHECK_EN
  logic [1:0]       ccnt;
`endif

  logic       data_last;
  logic       frame_last;
  logic       take;
  logic [2:0] res_base;
  logic [2:0] res_nxt;

  function automatic logic [2:0] step5(input logic [2:0] r, input logic b);
    logic [2:0] n;
    case ({r, b})
      4'b000_0: n = 3'd0;
      4'b000_1: n = 3'd1;
      4'b001_0: n = 3'd2;
      4'b001_1: n = 3'd3;
      4'b010_0: n = 3'd4;
      4'b010_1: n = 3'd0;
      4'b011_0: n = 3'd1;
      4'b011_1: n = 3'd2;
      4'b100_0: n = 3'd3;
      4'b100_1: n = 3'd4;
      default:  n = 3'd0;
    endcase
    return n;
  endfunction

  assign data_last = (state == DATA) && (cnt == CW'(WIDTH - 1));
`ifdef RESIDUE_TX_CHECK_EN
  assign frame_last = (state == CHK) && (ccnt == 2'd2);
`else
  assign frame_last = data_last;
`endif
  assign bus.in_ready = (state == IDLE) || frame_last;
  assign take         = bus.in_valid && bus.in_ready;

  // On a back-to-back load res still shows the previous frame's final value,
  // so the first data bit of a frame always starts the residue from zero.
  assign res_base = frame_start_q ? 3'd0 : res_q;
  assign res_nxt  = step5(res_base, ser_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      sh            <= '0;
      cnt           <= '0;
      ser_q         <= 1'b0;
      ser_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      chk_phase_q   <= 1'b0;
      res_q         <= 3'd0;
      frame_done_q  <= 1'b0;
`ifdef RESIDUE_TX_CHECK_EN
      ccnt          <= 2'd0;
`endif
    end else begin
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (res_q > 3'd4) res_q <= 3'd0;
        end
        DATA: begin
          res_q <= res_nxt;
          cnt   <= cnt + CW'(1);
          if (!data_last) begin
            ser_q <= sh[WIDTH-1];
            sh    <= sh << 1;
          end else begin
`ifdef RESIDUE_TX_CHECK_EN
            state       <= CHK;
            ccnt        <= 2'd0;
            chk_phase_q <= 1'b1;
            ser_q       <= res_nxt[2];
`else
            frame_done_q <= 1'b1;
            state        <= IDLE;
            ser_q        <= 1'b0;
            ser_valid_q  <= 1'b0;
`endif
          end
        end
`ifdef RESIDUE_TX_CHECK_EN
        CHK: begin
          if (res_q > 3'd4) res_q <= 3'd0;
          ccnt <= ccnt + 2'd1;
          case (ccnt)
            2'd0:    ser_q <= res_q[1];
            2'd1:    ser_q <= res_q[0];
            default: begin
              frame_done_q <= 1'b1;
              state        <= IDLE;
              ser_q        <= 1'b0;
              ser_valid_q  <= 1'b0;
              chk_phase_q  <= 1'b0;
            end
          endcase
        end
`endif
        default: begin
          state       <= IDLE;
          ser_q       <= 1'b0;
          ser_valid_q <= 1'b0;
          chk_phase_q <= 1'b0;
          res_q       <= 3'd0;
        end
      endcase

      // A load overrides the return-to-idle assignments above.
      if (take) begin
        state         <= DATA;
        sh            <= bus.in_data << 1;
        ser_q         <= bus.in_data[WIDTH-1];
        ser_valid_q   <= 1'b1;
        frame_start_q <= 1'b1;
        chk_phase_q   <= 1'b0;
        cnt           <= '0;
        if (state == IDLE) res_q <= 3'd0;
      end
    end
  end

  assign bus.ser_out     = ser_q;
  assign bus.ser_valid   = ser_valid_q;
  assign bus.frame_start = frame_start_q;
  assign bus.chk_phase   = chk_phase_q;
  assign bus.res         = res_q;
  assign bus.frame_done  = frame_done_q;
endmodule
